// File: rtl/qs_pkg.sv
// Shared types and helpers for the multi-context sort-range stack.
package qs_pkg;

  // Stack command opcodes; encodings 5..7 are illegal.
  typedef enum logic [2:0] {
    NOP  = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    PEEK = 3'd3,
    CLR  = 3'd4
  } mstack_op_t;

  // Context-select width; a single context still gets a 1-bit field.
  function automatic int unsigned mstack_ctxw(input int unsigned c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

endpackage

// File: rtl/qs_srt_mstack_if.sv
// Command/response bus of the multi-context stack.
interface qs_srt_mstack_if #(
  parameter int unsigned C = 4,
  parameter int unsigned W = 32
);
  localparam int unsigned CTXW = qs_pkg::mstack_ctxw(C);

  logic            cmd_vld;
  logic [2:0]      cmd_op;
  logic [CTXW-1:0] cmd_ctx;
  logic [W-1:0]    cmd_dat;
  logic            cmd_err_w;
  logic            rsp_vld_r;
  logic [CTXW-1:0] rsp_ctx_r;
  logic [W-1:0]    rsp_dat_r;

  modport master (
    output cmd_vld, cmd_op, cmd_ctx, cmd_dat,
    input  cmd_err_w, rsp_vld_r, rsp_ctx_r, rsp_dat_r
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_ctx, cmd_dat,
    output cmd_err_w, rsp_vld_r, rsp_ctx_r, rsp_dat_r
  );
endinterface

// File: rtl/qs_srt_mstack_ctx.sv
// Per-context occupancy, status flags and slot index for one stack.
module qs_srt_mstack_ctx
  import qs_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  mstack_op_t           op,
  output logic [$clog2(N)-1:0] index,
  output logic                 err,
  output logic                 empty_r,
  output logic                 full_r,
  output logic                 err_r
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = IW + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          is_push;
  logic          is_rd;

  // Slot index, legality and next occupancy for the current command.
  always_comb begin
    is_push = sel && (op == PUSH);
    is_rd   = sel && ((op == POP) || (op == PEEK));
    index   = cnt[IW-1:0];
    if (is_rd) index = IW'(cnt - CW'(1));
    err     = (is_push && full_r) || (is_rd && empty_r);
    cnt_nxt = cnt;
    if (sel) begin
      case (op)
        PUSH:    if (!full_r)  cnt_nxt = cnt + CW'(1);
        POP:     if (!empty_r) cnt_nxt = cnt - CW'(1);
        CLR:     cnt_nxt = '0;
        default: cnt_nxt = cnt;
      endcase
    end
  end

  // Occupancy with empty/full registered alongside it; sticky error until CLR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      empty_r <= (cnt_nxt == '0);
      full_r  <= (cnt_nxt == CW'(N));
      if (sel && (op == CLR)) err_r <= 1'b0;
      else if (err)           err_r <= 1'b1;
    end
  end
endmodule

// File: rtl/qs_srt_mstack.sv
// Multi-context LIFO: C stacks of N words sharing one single-port SRAM.
module qs_srt_mstack
  import qs_pkg::*;
#(
  parameter int unsigned C = 4,
  parameter int unsigned N = 16,
  parameter int unsigned W = 32
) (
  input  logic          clk,
  input  logic          rst,
  qs_srt_mstack_if.slave bus,
  output logic [C-1:0]  empty_r,
  output logic [C-1:0]  full_r,
  output logic [C-1:0]  err_r
);
  localparam int unsigned CTXW = mstack_ctxw(C);
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned AW   = $clog2(C * N);

  logic            legal;
  mstack_op_t      op_eff;
  logic [C-1:0]    sel;
  logic [C-1:0]    err_arr;
  logic [IW-1:0]   idx_arr [C];
  logic [IW-1:0]   idx;
  logic            ctx_err;
  logic            ctx_hit;
  logic            do_wr;
  logic            do_rd;
  logic [AW-1:0]   addr;
  logic [W-1:0]    rd_dat;
  logic [W-1:0]    mem [C*N];

  // Decode: illegal opcodes and idle cycles reach the contexts as NOP.
  always_comb begin
    legal  = (bus.cmd_op <= 3'd4);
    op_eff = (bus.cmd_vld && legal) ? mstack_op_t'(bus.cmd_op) : NOP;
  end

  for (genvar c = 0; c < C; c++) begin : g_ctx
    assign sel[c] = (bus.cmd_ctx == CTXW'(c));

    qs_srt_mstack_ctx #(.N(N)) u_ctx (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel[c]),
      .op      (op_eff),
      .index   (idx_arr[c]),
      .err     (err_arr[c]),
      .empty_r (empty_r[c]),
      .full_r  (full_r[c]),
      .err_r   (err_r[c])
    );
  end

  // Select the addressed context's slot index and error.
  always_comb begin
    idx     = '0;
    ctx_err = 1'b0;
    for (int unsigned c = 0; c < C; c++) begin
      if (sel[c]) begin
        idx     = idx_arr[c];
        ctx_err = err_arr[c];
      end
    end
    ctx_hit       = |sel;
    do_wr         = ctx_hit && (op_eff == PUSH) && !ctx_err;
    do_rd         = ctx_hit && ((op_eff == POP) || (op_eff == PEEK)) && !ctx_err;
    addr          = AW'({bus.cmd_ctx, idx});
    bus.cmd_err_w = bus.cmd_vld && (!legal || ctx_err);
  end

  // Single-port SRAM with asynchronous read data; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[addr] <= bus.cmd_dat;
  end

  assign rd_dat = mem[addr];

  // Registered response; a reset drops any response in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_vld_r <= 1'b0;
      bus.rsp_ctx_r <= '0;
      bus.rsp_dat_r <= '0;
    end else begin
      bus.rsp_vld_r <= do_rd;
      if (do_rd) begin
        bus.rsp_ctx_r <= bus.cmd_ctx;
        bus.rsp_dat_r <= rd_dat;
      end
    end
  end
endmodule

// File: tb/tb_qs_srt_mstack.sv
// Directed bench for qs_srt_mstack (C=4, N=4, W=8) with a behavioural stack model.
module tb_qs_srt_mstack;
  localparam int C = 4;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [C-1:0] empty_r, full_r, err_r;

  qs_srt_mstack_if #(.C(C), .W(W)) bus ();

  qs_srt_mstack #(.C(C), .N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .empty_r (empty_r),
    .full_r  (full_r),
    .err_r   (err_r)
  );

  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: per-context word arrays with occupancy and sticky error.
  logic [W-1:0] mdat [C][N];
  int           msz  [C];
  bit           merr [C];
  bit           exp_vld;
  logic [1:0]   exp_ctx;
  logic [W-1:0] exp_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [C-1:0] m_empty();
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = (msz[c] == 0);
    return v;
  endfunction

  function automatic logic [C-1:0] m_full();
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = (msz[c] == N);
    return v;
  endfunction

  function automatic logic [C-1:0] m_errv();
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = merr[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      msz[c]  = 0;
      merr[c] = 1'b0;
    end
    exp_vld = 1'b0;
    exp_ctx = '0;
    exp_dat = '0;
  endtask

  // Registered outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rsp_vld_r", 32'(bus.rsp_vld_r), 32'(exp_vld));
      chk("rsp_ctx_r", 32'(bus.rsp_ctx_r), 32'(exp_ctx));
      chk("rsp_dat_r", 32'(bus.rsp_dat_r), 32'(exp_dat));
      chk("empty_r",   32'(empty_r),       32'(m_empty()));
      chk("full_r",    32'(full_r),        32'(m_full()));
      chk("err_r",     32'(err_r),         32'(m_errv()));
    end
  end

  // One command cycle: drive at negedge, check cmd_err_w, advance model at posedge.
  task automatic step(input bit v, input logic [2:0] op, input int ctx,
                      input logic [W-1:0] d, output bit err_seen);
    bit legal, m_err, rsp;
    logic [W-1:0] rd;
    @(negedge clk);
    bus.cmd_vld = v;
    bus.cmd_op  = op;
    bus.cmd_ctx = 2'(ctx);
    bus.cmd_dat = d;
    legal = (op <= 3'd4);
    m_err = v && (!legal || (op == 3'd1 && msz[ctx] == N) ||
                  ((op == 3'd2 || op == 3'd3) && msz[ctx] == 0));
    rd = '0;
    #1;
    err_seen = bus.cmd_err_w;
    chk("cmd_err_w", 32'(err_seen), 32'(m_err));
    @(posedge clk);
    rsp = 1'b0;
    if (v && legal) begin
      case (op)
        3'd1: if (m_err) merr[ctx] = 1'b1;
              else begin mdat[ctx][msz[ctx]] = d; msz[ctx]++; end
        3'd2, 3'd3: if (m_err) merr[ctx] = 1'b1;
              else begin
                rd  = mdat[ctx][msz[ctx]-1];
                rsp = 1'b1;
                if (op == 3'd2) msz[ctx]--;
              end
        3'd4: begin msz[ctx] = 0; merr[ctx] = 1'b0; end
        default: ;
      endcase
    end
    exp_vld = rsp;
    if (rsp) begin
      exp_ctx = 2'(ctx);
      exp_dat = rd;
    end
  endtask

  bit e;
  logic [W-1:0] pops [4];

  initial begin
    pops[0] = 8'h44; pops[1] = 8'h33; pops[2] = 8'h22; pops[3] = 8'h11;
    bus.cmd_vld = 1'b0;
    bus.cmd_op  = 3'd0;
    bus.cmd_ctx = '0;
    bus.cmd_dat = '0;
    model_reset();

    // Reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset empty_r", 32'(empty_r), 32'h0f);
    chk("reset full_r", 32'(full_r), 32'h0);
    chk("reset err_r", 32'(err_r), 32'h0);
    chk("reset rsp_vld_r", 32'(bus.rsp_vld_r), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Single context fill and drain
    step(1, 3'd1, 2, 8'h11, e);
    step(1, 3'd1, 2, 8'h22, e);
    step(1, 3'd1, 2, 8'h33, e);
    step(1, 3'd1, 2, 8'h44, e);
    #1 chk("full after 4 pushes", 32'(full_r), 32'h4);
    for (int i = 0; i < 4; i++) begin
      step(1, 3'd2, 2, 8'h00, e);
      #1;
      chk("pop data", 32'(bus.rsp_dat_r), 32'(pops[i]));
      chk("pop ctx", 32'(bus.rsp_ctx_r), 32'd2);
      chk("pop vld", 32'(bus.rsp_vld_r), 32'd1);
    end
    chk("empty after drain", 32'(empty_r[2]), 32'd1);

    // Errors
    for (int i = 0; i < 5; i++) step(1, 3'd1, 1, 8'(8'h10 + i), e);
    chk("5th push err", 32'(e), 32'd1);
    #1 chk("err_r[1] set", 32'(err_r[1]), 32'd1);
    step(1, 3'd2, 1, 8'h00, e);
    #1 chk("contents kept", 32'(bus.rsp_dat_r), 32'h13);
    step(1, 3'd2, 3, 8'h00, e);
    chk("pop empty err", 32'(e), 32'd1);
    #1 chk("no rsp on empty pop", 32'(bus.rsp_vld_r), 32'd0);
    step(1, 3'd5, 0, 8'h00, e);
    chk("illegal op err", 32'(e), 32'd1);
    step(1, 3'd4, 1, 8'h00, e);
    #1;
    chk("clr err_r[1]", 32'(err_r[1]), 32'd0);
    chk("clr empty_r[1]", 32'(empty_r[1]), 32'd1);
    step(1, 3'd4, 3, 8'h00, e);

    // Interleave
    step(1, 3'd1, 0, 8'hA0, e);
    step(1, 3'd1, 1, 8'hB0, e);
    step(1, 3'd1, 0, 8'hA1, e);
    step(1, 3'd3, 0, 8'h00, e);
    #1 chk("peek ctx0", 32'(bus.rsp_dat_r), 32'hA1);
    step(1, 3'd2, 1, 8'h00, e);
    #1 chk("pop ctx1", 32'(bus.rsp_dat_r), 32'hB0);
    step(1, 3'd2, 0, 8'h00, e);
    #1 chk("pop ctx0", 32'(bus.rsp_dat_r), 32'hA1);
    chk("ctx0 not empty", 32'(empty_r[0]), 32'd0);
    step(0, 3'd2, 0, 8'h00, e);
    step(1, 3'd0, 0, 8'h00, e);

    // Back-to-back push/peek and pop/push
    step(1, 3'd1, 3, 8'h5A, e);
    step(1, 3'd3, 3, 8'h00, e);
    #1 chk("b2b peek", 32'(bus.rsp_dat_r), 32'h5A);
    step(1, 3'd2, 3, 8'h00, e);
    step(1, 3'd1, 3, 8'h77, e);
    step(1, 3'd3, 3, 8'h00, e);
    #1 chk("overwrite freed slot", 32'(bus.rsp_dat_r), 32'h77);

    // Mid-operation reset
    step(1, 3'd2, 0, 8'h00, e);
    #1 chk("pop before reset", 32'(bus.rsp_dat_r), 32'hA0);
    chk_en = 1'b0;
    bus.cmd_vld = 1'b0;
    #1 rst = 1'b0;
    #1 chk("rsp dropped by reset", 32'(bus.rsp_vld_r), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("empty after reset", 32'(empty_r), 32'h0f);
    chk_en = 1'b1;
    step(1, 3'd2, 0, 8'h00, e);
    step(0, 3'd0, 0, 8'h00, e);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
